// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add RV32 MUL sequencer. The shared ALU's add path is reused,
// so each RUN cycle folds one partial product into the accumulator.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result holds the last product
// RUN   | one multiplier bit per cycle: acc <= acc + (bit ? mcand : 0)
// DONE  | one-cycle done pulse; a start here is accepted with no bubble
module mul_seq_ctrl #(
   parameter int                       INPUT_WIDTH   = 32,
   parameter int                       CONTROL_WIDTH = 3,
   parameter logic [CONTROL_WIDTH-1:0] ADD_CODE      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     flush,
   input  logic [INPUT_WIDTH-1:0]   op_a,
   input  logic [INPUT_WIDTH-1:0]   op_b,
   output logic [INPUT_WIDTH-1:0]   alu_op1,
   output logic [INPUT_WIDTH-1:0]   alu_op2,
   output logic [CONTROL_WIDTH-1:0] alu_ctrl,
   input  logic [INPUT_WIDTH-1:0]   alu_out,
   output logic [INPUT_WIDTH-1:0]   result,
   output logic                     done,
   output logic                     busy,
   output logic                     stall
);

   localparam int CNT_W = $clog2(INPUT_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]             state;
   logic [INPUT_WIDTH-1:0] acc;
   logic [INPUT_WIDTH-1:0] mcand;
   logic [INPUT_WIDTH-1:0] mplier;
   logic [CNT_W-1:0]       cnt;

   logic in_run;
   logic last_iter;

   assign in_run = (state == RUN);

   // Stop as soon as no set multiplier bits remain; cnt caps the width.
   assign last_iter = ((mplier >> 1) == '0) || (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  acc    <= '0;
                  mcand  <= op_a;
                  mplier <= op_b;
                  cnt    <= '0;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc    <= alu_out;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last_iter) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alu_op1  = acc;
   assign alu_op2  = (in_run && mplier[0]) ? mcand : '0;
   assign alu_ctrl = ADD_CODE;

   assign result = acc;
   assign done   = (state == DONE);
   assign busy   = in_run;
   assign stall  = in_run | (start & ~in_run & ~flush);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed table, random operands
// against a product/iteration-count model, and flush/reset corner sequences.
module tb_mul_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_out;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic        stall;

   int n_cmp = 0;
   int n_err = 0;

   mul_seq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .flush    (flush),
      .op_a     (op_a),
      .op_b     (op_b),
      .alu_op1  (alu_op1),
      .alu_op2  (alu_op2),
      .alu_ctrl (alu_ctrl),
      .alu_out  (alu_out),
      .result   (result),
      .done     (done),
      .busy     (busy),
      .stall    (stall)
   );

   // ALU stand-in: only the add code produces a sum.
   assign alu_out = (alu_ctrl == 3'h0) ? alu_op1 + alu_op2 : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_n;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_n(input logic [31:0] b);
      int n = 1;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      return n;
   endfunction

   // Caller is at cycle 0 (just after an edge). Leaves start high at the DONE
   // cycle when keep_start is set, so the next call is a back-to-back start.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_n,
                          input bit keep_start, input string nm);
      logic [31:0] mask;
      logic [31:0] part;
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      #1;
      chk({nm, " stall_c0"}, 32'(stall), 32'd1);
      for (int k = 1; k <= exp_n; k++) begin
         tick();
         mask = (k == 1) ? 32'd0 : (32'hFFFF_FFFF >> (33 - k));
         part = a * (b & mask);
         if (k == 1 || k == exp_n) begin
            chk({nm, " busy"}, 32'(busy), 32'd1);
            chk({nm, " stall_run"}, 32'(stall), 32'd1);
         end
         chk({nm, " done_run"}, 32'(done), 32'd0);
         chk({nm, " alu_op1"}, alu_op1, part);
         chk({nm, " alu_op2"}, alu_op2, b[k-1] ? (a << (k - 1)) : 32'd0);
         chk({nm, " alu_ctrl"}, 32'(alu_ctrl), 32'd0);
      end
      tick();
      chk({nm, " done"}, 32'(done), 32'd1);
      chk({nm, " result"}, result, exp_res);
      chk({nm, " busy_done"}, 32'(busy), 32'd0);
      if (!keep_start) begin
         start = 1'b0;
         #1;
         chk({nm, " stall_done"}, 32'(stall), 32'd0);
         tick();
         chk({nm, " done_gone"}, 32'(done), 32'd0);
         chk({nm, " result_hold"}, result, exp_res);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{32'd7,        32'd6,        32'd42,       3};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32};
      vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 17};
      vecs[3] = '{32'd123,      32'd0,        32'd0,        1};
      vecs[4] = '{32'd5,        32'd1,        32'd5,        1};

      rst = 1'b1; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst result", result, 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst alu_op1", alu_op1, 32'd0);
      chk("rst alu_op2", alu_op2, 32'd0);
      tick();

      foreach (vecs[i]) run_mul(vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_n, 1'b0,
                                $sformatf("vec%0d", i));

      // Back-to-back: 3*4 then 9*9 started during the DONE cycle.
      run_mul(32'd3, 32'd4, 32'd12, 3, 1'b1, "b2b_first");
      run_mul(32'd9, 32'd9, 32'd81, 4, 1'b0, "b2b_second");

      // Abort mid-RUN; a start presented alongside flush must not launch.
      start = 1'b1; op_a = 32'd5; op_b = 32'hFF;
      tick();
      tick();
      tick();
      flush = 1'b1;
      #1;
      chk("flush c3 busy", 32'(busy), 32'd1);
      tick();
      chk("flush c4 busy", 32'(busy), 32'd0);
      chk("flush c4 done", 32'(done), 32'd0);
      #1;
      chk("flush+start stall", 32'(stall), 32'd0);
      tick();
      chk("flush+start busy", 32'(busy), 32'd0);
      chk("flush+start done", 32'(done), 32'd0);
      flush = 1'b0; start = 1'b0;
      tick();
      chk("post flush done", 32'(done), 32'd0);
      run_mul(32'd2, 32'd3, 32'd6, 2, 1'b0, "after_flush");

      // Reset mid-RUN clears acc and returns to IDLE without a done pulse.
      start = 1'b1; op_a = 32'd11; op_b = 32'hF0;
      tick();
      tick();
      start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_run busy", 32'(busy), 32'd0);
      chk("rst_run done", 32'(done), 32'd0);
      chk("rst_run result", result, 32'd0);
      tick();
      chk("rst_run done2", 32'(done), 32'd0);

      for (int t = 0; t < 24; t++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_mul(ra, rb, ra * rb, model_n(rb), 1'b0, $sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Iterative shift-add multiply sequencer for the execute stage. It implements the RV32 MUL (low 32 bits of product) by reusing the shared ALU's add path, driving the ALU operand and control inputs one partial product per cycle and capturing the ALU output back into an accumulator. It asserts a stall toward the pipeline while busy and presents the result with a one-cycle done pulse.

## Interface
- INPUT_WIDTH, 32: operand, result and ALU datapath width.
- CONTROL_WIDTH, 3: ALU control width.
- ADD_CODE, 3'h0: ALU control code selecting ALUop1 + ALUop2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply using op_a/op_b this cycle.
- flush  input  1  synchronous abort of any operation in progress.
- op_a  input  INPUT_WIDTH  multiplicand.
- op_b  input  INPUT_WIDTH  multiplier.
- alu_op1  output  INPUT_WIDTH  to ALU ALUop1.
- alu_op2  output  INPUT_WIDTH  to ALU ALUop2.
- alu_ctrl  output  CONTROL_WIDTH  to ALU ALUctrl; constant ADD_CODE.
- alu_out  input  INPUT_WIDTH  from ALU ALUout.
- result  output  INPUT_WIDTH  low INPUT_WIDTH bits of op_a*op_b.
- done  output  1  one-cycle pulse; result valid.
- busy  output  1  state is RUN.
- stall  output  1  combinational pipeline freeze.

## Operation
- States: IDLE, RUN, DONE. Registers: acc, mcand, mplier, cnt (clog2(INPUT_WIDTH) bits), state.
- IDLE or DONE with start=1 (and flush=0): acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, go RUN. Otherwise DONE->IDLE, IDLE holds.
- RUN, each cycle: alu_op1=acc, alu_op2 = mplier[0] ? mcand : 0. acc<=alu_out, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
- RUN exit: go DONE when (mplier>>1)==0 or cnt==INPUT_WIDTH-1; else stay RUN. Iterations N = max(1, index of highest set bit of op_b + 1); op_b=0 gives N=1.
- Arithmetic is modulo 2^INPUT_WIDTH; bits shifted out of mcand are dropped. The product is sign-agnostic; no signed/high variants.
- Outside RUN: alu_op1=acc, alu_op2=0, alu_ctrl=ADD_CODE always.
- result=acc. It holds its value in DONE and IDLE until the next accepted start clears it.
- done=1 only in DONE. busy=1 only in RUN.
- stall = (state==RUN) | (start & state!=RUN & ~flush).
- start in RUN is ignored. The requester holds start and operands while stall is high.
- flush=1 in any state forces IDLE next cycle with no done pulse. acc is not cleared. flush has priority over start.
- rst has priority over everything.

## Timing
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0. Hence result=0, done=0, busy=0, stall=start, alu_op1=0, alu_op2=0, alu_ctrl=ADD_CODE.
- Start accepted at cycle 0. RUN occupies cycles 1..N. done=1 and result valid at cycle N+1. Latency is N+1 cycles (2 minimum, INPUT_WIDTH+1 maximum).
- Back-to-back: start at the DONE cycle is accepted. RUN begins the next cycle, with no idle bubble.
- The ALU path is combinational within one cycle; acc captures alu_out at the same edge the shift registers update.
- Reset or flush mid-RUN: IDLE on the next cycle, busy=0, and no done pulse follows.

## Test plan
- Reset then idle: rst high 2 cycles, then low -> result=0, done=0, busy=0, alu_ctrl=3'h0, stall=0.
- op_a=7, op_b=6, start at cycle 0 -> busy cycles 1-3, done at cycle 4 with result=42. stall is high at cycles 0-3 and low at cycle 4.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done at cycle 33, result=0x00000001. Separately, op_a=0x10000, op_b=0x10000 -> done at cycle 18, result=0 (wrap).
- op_a=123, op_b=0 -> done at cycle 2, result=0. Separately, op_a=5, op_b=1 -> done at cycle 2, result=5.
- Back-to-back: 3*4, then start with op_a=9, op_b=9 during the DONE cycle -> first done shows 12. The second done follows 5 cycles later (N=4) with 81.
- Abort: op_a=5, op_b=0xFF, flush at cycle 3 -> IDLE at cycle 4 with no done pulse. A start in the same cycle as flush is ignored. A subsequent start for 2*3 -> result=6.
